// File: rtl/ldm_stm_seq_if.sv
// Register-file and memory bus bundle for the LDM/STM block-transfer sequencer.
//   Register-file side: rd_sel/rd_data (read, data one cycle after select),
//                       wr_en/wr_sel/wr_data (write strobe).
//   Memory side:        mem_req/mem_we/mem_addr/mem_wdata (single-beat request,
//                       held until ack), mem_ack/mem_rdata (beat completion).
// master = sequencer, slave = register file + memory.
interface ldm_stm_seq_if #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
);
  logic [SEL_W-1:0]  rd_sel;
  logic [DATA_W-1:0] rd_data;
  logic              wr_en;
  logic [SEL_W-1:0]  wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output rd_sel, wr_en, wr_sel, wr_data,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  rd_data, mem_ack, mem_rdata
  );

  modport slave (
    input  rd_sel, wr_en, wr_sel, wr_data,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output rd_data, mem_ack, mem_rdata
  );
endinterface

// File: rtl/ldm_stm_seq.sv
// Multi-cycle sequencer for ARM LDM/STM block transfers.
// Walks the latched register list lowest register first, at ascending
// addresses, one word per memory beat, then optionally writes the final
// address back to the base register.
// Ports:
//   clock, reset_n        clock, asynchronous active-low reset
//   start                 one-cycle request, sampled only in IDLE
//   is_load/pre/up/wback  L, P, U, W bits of the instruction
//   reg_list              register mask, bit n = rn
//   base, base_sel        base register value and number
//   busy, done            busy from SETUP through WB; one-cycle done pulse
//   bus                   register-file and memory bus (master side)
module ldm_stm_seq #(
  parameter int DATA_W = 32,
  parameter int NREGS  = 16
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic                     is_load,
  input  logic                     pre,
  input  logic                     up,
  input  logic                     wback,
  input  logic [NREGS-1:0]         reg_list,
  input  logic [DATA_W-1:0]        base,
  input  logic [$clog2(NREGS)-1:0] base_sel,
  output logic                     busy,
  output logic                     done,
  ldm_stm_seq_if.master            bus
);
  localparam int SEL_W = $clog2(NREGS);
  localparam int CNT_W = $clog2(NREGS + 1);
  localparam int PAD_W = DATA_W - CNT_W - 2;
  localparam logic [DATA_W-1:0] WORD = DATA_W'(4);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_RSEL  = 3'd2;
  localparam logic [2:0] S_XFER  = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  function automatic logic [CNT_W-1:0] popcnt(input logic [NREGS-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < NREGS; i++)
      if (v[i]) c = c + CNT_W'(1);
    return c;
  endfunction

  function automatic logic [SEL_W-1:0] lowest(input logic [NREGS-1:0] v);
    logic [SEL_W-1:0] r;
    r = '0;
    for (int i = NREGS - 1; i >= 0; i--)
      if (v[i]) r = SEL_W'(i);
    return r;
  endfunction

  logic [2:0]        state;
  logic              ld_q, pre_q, up_q, wb_q, sup_q;
  logic [NREGS-1:0]  list_q;
  logic [DATA_W-1:0] base_q, addr_q, final_q, wdata_q;
  logic [SEL_W-1:0]  bsel_q;
  logic              wd_live;
  logic              wr_en_q;
  logic [SEL_W-1:0]  wr_sel_q;
  logic [DATA_W-1:0] wr_data_q;

  logic [CNT_W+1:0]  cnt4;
  logic [DATA_W-1:0] span, lo_addr, fin_addr;
  logic [NREGS-1:0]  list_rest;
  logic [SEL_W-1:0]  cur_reg;
  logic              xfer;

  // Transfers always walk upward from the lowest address, so descending
  // modes only differ in where that lowest address sits.
  assign cnt4     = {popcnt(list_q), 2'b00};
  assign span     = {{PAD_W{1'b0}}, cnt4};
  assign lo_addr  = up_q ? (pre_q ? base_q + WORD : base_q)
                         : (pre_q ? base_q - span : base_q - span + WORD);
  assign fin_addr = up_q ? base_q + span : base_q - span;

  // Clearing the lowest set bit retires the register just transferred.
  assign list_rest = list_q & (list_q - NREGS'(1));
  assign cur_reg   = lowest(list_q);
  assign xfer      = (state == S_XFER);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      ld_q      <= 1'b0;
      pre_q     <= 1'b0;
      up_q      <= 1'b0;
      wb_q      <= 1'b0;
      sup_q     <= 1'b0;
      list_q    <= '0;
      base_q    <= '0;
      addr_q    <= '0;
      final_q   <= '0;
      wdata_q   <= '0;
      bsel_q    <= '0;
      wd_live   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_sel_q  <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            ld_q   <= is_load;
            pre_q  <= pre;
            up_q   <= up;
            wb_q   <= wback;
            // A load into the base register takes priority over writeback.
            sup_q  <= is_load & reg_list[base_sel];
            list_q <= reg_list;
            base_q <= base;
            bsel_q <= base_sel;
            state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          addr_q  <= lo_addr;
          final_q <= fin_addr;
          if (list_q == '0) state <= S_DONE;
          else if (ld_q)    state <= S_XFER;
          else              state <= S_RSEL;
        end
        S_RSEL: begin
          wd_live <= 1'b1;
          state   <= S_XFER;
        end
        S_XFER: begin
          // Store data arrives from the register file in the first XFER
          // cycle; capture it there so it stays put while waiting for ack.
          if (wd_live) begin
            wdata_q <= bus.rd_data;
            wd_live <= 1'b0;
          end
          if (bus.mem_ack) begin
            list_q <= list_rest;
            addr_q <= addr_q + WORD;
            if (ld_q) begin
              wr_en_q   <= 1'b1;
              wr_sel_q  <= cur_reg;
              wr_data_q <= bus.mem_rdata;
            end
            if (list_rest == '0) state <= S_WB;
            else if (ld_q)       state <= S_XFER;
            else                 state <= S_RSEL;
          end
        end
        S_WB: begin
          // Registered so it cannot collide with the last load's write,
          // which is on the port during this cycle.
          if (wb_q && !sup_q) begin
            wr_en_q   <= 1'b1;
            wr_sel_q  <= bsel_q;
            wr_data_q <= final_q;
          end
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_SETUP) || (state == S_RSEL) ||
                (state == S_XFER)  || (state == S_WB);
  assign done = (state == S_DONE);

  assign bus.rd_sel    = cur_reg;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_sel    = wr_sel_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.mem_req   = xfer;
  assign bus.mem_we    = xfer & ~ld_q;
  assign bus.mem_addr  = xfer ? addr_q : '0;
  assign bus.mem_wdata = (xfer && !ld_q) ? (wd_live ? bus.rd_data : wdata_q) : '0;
endmodule

// File: tb/tb_ldm_stm_seq.sv
// Directed bench for ldm_stm_seq: register-file stub with fixed contents,
// memory stub with programmable ack delay and mem_rdata = addr ^ 0xFFFF,
// and a transaction-level model of expected beats, writes and timing.
module tb_ldm_stm_seq;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start, is_load, pre, up, wback;
  logic [15:0] reg_list;
  logic [31:0] base;
  logic [3:0]  base_sel;
  logic        busy, done;

  always #5 clock = ~clock;

  ldm_stm_seq_if #(.DATA_W(32), .SEL_W(4)) bus ();

  ldm_stm_seq #(.DATA_W(32), .NREGS(16)) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .is_load  (is_load),
    .pre      (pre),
    .up       (up),
    .wback    (wback),
    .reg_list (reg_list),
    .base     (base),
    .base_sel (base_sel),
    .busy     (busy),
    .done     (done),
    .bus      (bus)
  );

  // Register-file stub: synchronous read, contents fixed at rN = 0xA0 + N.
  logic [31:0] regs [16];
  always @(posedge clock) bus.rd_data <= regs[bus.rd_sel];

  // Memory stub: ack after ack_delay waiting cycles.
  int ack_delay = 0;
  int req_cnt = 0;
  always @(posedge clock)
    if (bus.mem_req && !bus.mem_ack) req_cnt <= req_cnt + 1;
    else                             req_cnt <= 0;
  assign bus.mem_ack   = bus.mem_req && (req_cnt >= ack_delay);
  assign bus.mem_rdata = bus.mem_addr ^ 32'h0000FFFF;

  // ---------------- model ----------------
  typedef struct { logic we; logic [31:0] addr; logic [31:0] data; } beat_t;
  typedef struct { logic [3:0] sel; logic [31:0] data; } wr_t;
  beat_t exp_beats[$];
  wr_t   exp_wrs[$];
  int    exp_lat, exp_hold;

  bit          op_ld, op_p, op_u, op_w;
  logic [15:0] op_lst;
  logic [31:0] op_b;
  logic [3:0]  op_bs;

  int vecs = 0;
  int errs = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  task automatic prep(input bit ld, p, u, w, input logic [15:0] lst,
                      input logic [31:0] b, input logic [3:0] bs, input int d);
    int n;
    logic [31:0] a;
    beat_t bt;
    wr_t wt;
    op_ld = ld; op_p = p; op_u = u; op_w = w;
    op_lst = lst; op_b = b; op_bs = bs;
    ack_delay = d;
    n = $countones(lst);
    exp_beats.delete();
    exp_wrs.delete();
    // Lowest address touched by the block.
    if (u) a = p ? b + 32'd4 : b;
    else   a = p ? b - 32'(4 * n) : b - 32'(4 * n) + 32'd4;
    for (int r = 0; r < 16; r++) begin
      if (lst[r]) begin
        bt.we = !ld; bt.addr = a; bt.data = ld ? 32'h0 : regs[r];
        exp_beats.push_back(bt);
        if (ld) begin
          wt.sel = 4'(r); wt.data = a ^ 32'h0000FFFF;
          exp_wrs.push_back(wt);
        end
        a = a + 32'd4;
      end
    end
    if (n > 0 && w && !(ld && lst[bs])) begin
      wt.sel = bs;
      wt.data = u ? b + 32'(4 * n) : b - 32'(4 * n);
      exp_wrs.push_back(wt);
    end
    exp_lat  = (n == 0) ? 2 : 3 + n * ((ld ? 1 : 2) + d);
    exp_hold = 1 + d;
  endtask

  // ---------------- compare process ----------------
  bit          active = 0;
  int          cyc = 0;
  int          hold = 0;
  logic [31:0] prev_addr, prev_wdata;
  logic        prev_we;

  always @(negedge clock) begin
    if (!reset_n) begin
      active = 0;
      hold = 0;
      exp_beats.delete();
      exp_wrs.delete();
      check("reset_outs", 32'({busy, done, bus.mem_req, bus.wr_en, bus.mem_addr != 32'h0}), 32'h0);
    end else begin
      if (bus.mem_req) begin
        hold++;
        if (hold > 1) begin
          check("hold_addr", bus.mem_addr, prev_addr);
          check("hold_wdata", bus.mem_wdata, prev_wdata);
          check("hold_we", 32'(bus.mem_we), 32'(prev_we));
        end
        prev_addr = bus.mem_addr; prev_wdata = bus.mem_wdata; prev_we = bus.mem_we;
        if (bus.mem_ack) begin
          if (exp_beats.size() == 0) check("extra_beat", 32'h1, 32'h0);
          else begin
            beat_t bt;
            bt = exp_beats.pop_front();
            check("beat_we", 32'(bus.mem_we), 32'(bt.we));
            check("beat_addr", bus.mem_addr, bt.addr);
            if (bt.we) check("beat_wdata", bus.mem_wdata, bt.data);
            check("beat_hold", 32'(hold), 32'(exp_hold));
          end
          hold = 0;
        end
      end
      if (bus.wr_en) begin
        if (exp_wrs.size() == 0) check("extra_write", 32'h1, 32'h0);
        else begin
          wr_t wt;
          wt = exp_wrs.pop_front();
          check("wr_sel", 32'(bus.wr_sel), 32'(wt.sel));
          check("wr_data", bus.wr_data, wt.data);
        end
      end
      if (start) begin
        active = 1;
        cyc = 0;
        hold = 0;
      end else if (active) begin
        cyc++;
        check("busy", 32'(busy), 32'(cyc < exp_lat));
        check("done", 32'(done), 32'(cyc == exp_lat));
        if (cyc >= exp_lat) begin
          active = 0;
          check("beats_missing", 32'(exp_beats.size()), 32'h0);
          check("writes_missing", 32'(exp_wrs.size()), 32'h0);
        end
      end else begin
        check("idle_outs", 32'({busy, done, bus.mem_req, bus.wr_en}), 32'h0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic launch();
    @(posedge clock); #1;
    is_load = op_ld; pre = op_p; up = op_u; wback = op_w;
    reg_list = op_lst; base = op_b; base_sel = op_bs;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (active && t < 300) begin
      @(posedge clock); #1;
      t++;
    end
    check("op_timeout", 32'(t < 300), 32'h1);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) regs[i] = 32'hA0 + 32'(i);
    start = 0; is_load = 0; pre = 0; up = 0; wback = 0;
    reg_list = '0; base = '0; base_sel = '0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;

    // STMIA r0-r3 at 0x100, writeback 0x110 to r14.
    prep(0, 0, 1, 1, 16'h000F, 32'h100, 4'd14, 0);
    check("pin_stmia_addr3", exp_beats[3].addr, 32'h10C);
    check("pin_stmia_data3", exp_beats[3].data, 32'hA3);
    check("pin_stmia_wb", exp_wrs[0].data, 32'h110);
    check("pin_stmia_lat", 32'(exp_lat), 32'd11);
    launch(); wait_idle();

    // LDMDB r4,r15 below 0x200, no writeback.
    prep(1, 1, 0, 0, 16'h8010, 32'h200, 4'd3, 0);
    check("pin_ldmdb_r4", exp_wrs[0].data, 32'hFE07);
    check("pin_ldmdb_r15sel", 32'(exp_wrs[1].sel), 32'd15);
    check("pin_ldmdb_r15", exp_wrs[1].data, 32'hFE03);
    check("pin_ldmdb_nwr", 32'(exp_wrs.size()), 32'd2);
    launch(); wait_idle();

    // STMIB r1 with 3-cycle ack delay: request held 4 cycles at 0x104.
    prep(0, 1, 1, 0, 16'h0002, 32'h100, 4'd0, 3);
    check("pin_stmib_addr", exp_beats[0].addr, 32'h104);
    check("pin_stmib_hold", 32'(exp_hold), 32'd4);
    launch(); wait_idle();

    // LDMIA with base r2 in list: loaded value wins, no writeback.
    prep(1, 0, 1, 1, 16'h0004, 32'h300, 4'd2, 0);
    check("pin_ldmia_nwr", 32'(exp_wrs.size()), 32'd1);
    check("pin_ldmia_r2", exp_wrs[0].data, 32'h0000FCFF);
    launch(); wait_idle();

    // Empty list: no beats, no writes, done two cycles after start.
    prep(0, 0, 1, 1, 16'h0000, 32'h100, 4'd1, 0);
    check("pin_empty_lat", 32'(exp_lat), 32'd2);
    launch(); wait_idle();

    // STMDA r1,r2 from 0x100: lowest address 0xFC, writeback 0xF8.
    prep(0, 0, 0, 1, 16'h0006, 32'h100, 4'd13, 0);
    check("pin_stmda_addr0", exp_beats[0].addr, 32'hFC);
    check("pin_stmda_wb", exp_wrs[0].data, 32'hF8);
    launch(); wait_idle();

    // LDMIA across the top of the address space.
    prep(1, 0, 1, 1, 16'h0003, 32'hFFFFFFFC, 4'd5, 0);
    check("pin_wrap_addr1", exp_beats[1].addr, 32'h0);
    check("pin_wrap_wb", exp_wrs[2].data, 32'h4);
    launch(); wait_idle();

    // Reset in the middle of a 4-register STM.
    prep(0, 0, 1, 1, 16'h000F, 32'h100, 4'd14, 0);
    launch();
    repeat (2) @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    check("rst_mem_req", 32'(bus.mem_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Fresh operation after reset.
    prep(1, 0, 1, 1, 16'h0003, 32'h400, 4'd9, 0);
    check("pin_post_wb", exp_wrs[2].data, 32'h408);
    launch(); wait_idle();

    repeat (2) @(posedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
